axis_frame_source: RTL and testbench

- AXI-Stream transmitter that generates framed pseudo-random 16-bit samples for the max-finder receiver.
- Each frame is a burst of frame_len beats with TLAST on the final beat. TREADY backpressure is honoured per AXI-Stream rules.
- Tracks the running maximum and a frame counter of the words it emitted, so a bench can scoreboard the receiver's result directly.
- Sits upstream of the max finder in both the testbench and the on-chip self-test path.

---
 rtl/axis_pkg.sv | 29 ++
 rtl/lfsr16.sv | 34 +++
 rtl/axis_frame_source.sv | 127 ++++++++++++
 tb/tb_axis_frame_source.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream frame source, the max-finder receiver
// and their benches.
//   STREAM_WIDTH_DEFAULT / DATA_BITS_DEFAULT : default TDATA and sample widths
//   LFSR_TAPS / LFSR_SEED_DEFAULT            : 16-bit Galois LFSR definition
//   axis_state_t                             : frame FSM state encoding
//   lfsr_step()                              : one Galois right-shift step
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int STREAM_WIDTH_DEFAULT = 32;
    localparam int DATA_BITS_DEFAULT    = 16;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } axis_state_t;

    // Galois right shift: the bit falling out of the bottom folds the taps in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used as the sample generator of the frame source.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, returns value to 16'h0001
//   load     : load load_val (takes priority over advance)
//   load_val : seed; zero is replaced by 16'h0001
//   advance  : step the LFSR once
//   value    : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import axis_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        advance,
    output logic [15:0] value
);

    // An all-zero state never leaves zero, so a zero seed is swapped for the
    // default seed instead of locking the generator up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            value <= (load_val == 16'h0000) ? LFSR_SEED_DEFAULT : load_val;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/axis_frame_source.sv
// ---------------------------------------------------------------------------
// axis_frame_source
// AXI-Stream transmitter emitting frames of pseudo-random samples, while
// tracking the maximum emitted word and the number of completed frames.
//   ACLK, ARESET : clock (rising edge) and async active-high reset
//   start        : request a frame (IDLE only); frame_len sampled with it
//   frame_len    : beats per frame; zero means the request is ignored
//   seed_load    : load seed into the LFSR (IDLE only, applied before start)
//   seed         : LFSR seed value
//   TDATA/TVALID/TLAST/TREADY : AXI-Stream master interface
//   busy         : high while sending and in the done cycle
//   done         : one-cycle pulse after the final handshake
//   frame_max    : maximum word emitted in the current or last frame
//   frame_count  : completed frames, wrapping
// The sample generator is a fixed 16-bit LFSR, so DATA_BITS must stay 16.
// ---------------------------------------------------------------------------
module axis_frame_source
    import axis_pkg::*;
#(
    parameter int STREAM_WIDTH = STREAM_WIDTH_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int LEN_W        = 16,
    parameter int CNT_W        = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [LEN_W-1:0]        frame_len,
    input  logic                    seed_load,
    input  logic [DATA_BITS-1:0]    seed,
    output logic [STREAM_WIDTH-1:0] TDATA,
    output logic                    TVALID,
    output logic                    TLAST,
    input  logic                    TREADY,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_BITS-1:0]    frame_max,
    output logic [CNT_W-1:0]        frame_count
);

    axis_state_t          state;
    logic [LEN_W-1:0]     remaining;
    logic [DATA_BITS-1:0] lfsr_value;
    logic                 handshake;
    logic                 accept_start;
    logic                 take_seed;
    logic                 last_beat;

    assign handshake    = (state == SEND) && TREADY;
    assign accept_start = (state == IDLE) && start && (frame_len != '0);
    assign take_seed    = (state == IDLE) && seed_load;
    assign last_beat    = (remaining == LEN_W'(1));

    // The seed is loaded on the same edge that accepts start, so the first
    // beat of that frame already shows the new seed.
    lfsr16 u_lfsr (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (take_seed),
        .load_val (seed),
        .advance  (handshake),
        .value    (lfsr_value)
    );

    // Frame FSM. remaining counts down to 1 and the frame ends on that beat,
    // so it never wraps even for the largest frame_len.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        remaining <= frame_len;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        remaining <= remaining - LEN_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Scoreboard aids: running max of handshaked words, completed-frame count.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            frame_max   <= '0;
            frame_count <= '0;
        end else begin
            if (accept_start) begin
                frame_max <= '0;
            end else if (handshake && (lfsr_value > frame_max)) begin
                frame_max <= lfsr_value;
            end
            if (state == DONE) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

    // Outputs decode straight from registered state so that reset clears
    // them immediately and they cannot change during a stall.
    always_comb begin
        TDATA  = '0;
        TVALID = (state == SEND);
        TLAST  = (state == SEND) && last_beat;
        busy   = (state == SEND) || (state == DONE);
        done   = (state == DONE);
        if (state == SEND) begin
            TDATA[DATA_BITS-1:0] = lfsr_value;
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_source
// Self-checking bench for axis_frame_source. A behavioural model tracks the
// LFSR sequence, frame max and frame count; each scenario task drives the DUT
// and compares the collected beats against the model or known constants.
// ---------------------------------------------------------------------------
module tb_axis_frame_source;

    localparam int SW = 32;
    localparam int DB = 16;
    localparam int LW = 16;
    localparam int CW = 8;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic           start;
    logic [LW-1:0]  frame_len;
    logic           seed_load;
    logic [DB-1:0]  seed;
    logic [SW-1:0]  TDATA;
    logic           TVALID;
    logic           TLAST;
    logic           TREADY;
    logic           busy;
    logic           done;
    logic [DB-1:0]  frame_max;
    logic [CW-1:0]  frame_count;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int unsigned    mdl_lfsr;
    int unsigned    mdl_count;
    logic [15:0]    exp_words[$];
    logic [15:0]    exp_max;

    // Beats collected from the DUT
    logic [SW-1:0]  got_data[$];
    logic           got_last[$];
    int             stall_viol;
    int             valid_drops;
    int             frame_cycles;
    bit             timed_out;
    logic           done_pulse1;
    logic           done_pulse2;
    logic           tvalid_after;
    int             ready_pat[8] = '{0, 0, 1, 0, 1, 1, 0, 1};

    axis_frame_source #(
        .STREAM_WIDTH (SW),
        .DATA_BITS    (DB),
        .LEN_W        (LW),
        .CNT_W        (CW)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .frame_len   (frame_len),
        .seed_load   (seed_load),
        .seed        (seed),
        .TDATA       (TDATA),
        .TVALID      (TVALID),
        .TLAST       (TLAST),
        .TREADY      (TREADY),
        .busy        (busy),
        .done        (done),
        .frame_max   (frame_max),
        .frame_count (frame_count)
    );

    always #5 ACLK = ~ACLK;

    // Overall time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference LFSR step written from the arithmetic rule: halve the state,
    // and if the state was odd fold in 0xB400.
    function automatic int unsigned model_next(input int unsigned s);
        if ((s % 2) == 1) return (s / 2) ^ 32'h0000B400;
        return s / 2;
    endfunction

    function automatic void model_seed(input logic [15:0] sd);
        mdl_lfsr = (sd == 16'h0000) ? 1 : int'(sd);
    endfunction

    // Predict the words of a completed frame of len beats and advance the model.
    function automatic void model_frame(input int len);
        exp_words.delete();
        exp_max = 16'h0000;
        for (int i = 0; i < len; i++) begin
            exp_words.push_back(mdl_lfsr[15:0]);
            if (mdl_lfsr[15:0] > exp_max) exp_max = mdl_lfsr[15:0];
            mdl_lfsr = model_next(mdl_lfsr);
        end
        mdl_count = (mdl_count + 1) % 256;
    endfunction

    // Pulse start (optionally with a seed) for one cycle; returns #1 after
    // the accepting edge.
    task automatic applyStimulus(input int len, input bit do_seed, input logic [15:0] sd);
        start     = 1'b1;
        frame_len = LW'(len);
        seed_load = do_seed;
        seed      = sd;
        @(posedge ACLK); #1;
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    // Drive TREADY and record every handshake until the TLAST handshake.
    // mode 0: TREADY high, 1: fixed pattern, 2: random.
    // inject_at >= 0 raises start and seed_load mid-frame on that cycle.
    task automatic collect(input int budget, input int mode, input int inject_at);
        logic [SW-1:0] held_data;
        logic          held_last;
        bit            stalled;
        int            since;
        got_data.delete();
        got_last.delete();
        stall_viol   = 0;
        valid_drops  = 0;
        timed_out    = 1'b0;
        done_pulse1  = 1'b0;
        done_pulse2  = 1'b0;
        tvalid_after = 1'b1;
        stalled      = 1'b0;
        since        = 0;
        held_data    = '0;
        held_last    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (inject_at >= 0 && c == inject_at) begin
                start     = 1'b1;
                frame_len = LW'(5);
                seed_load = 1'b1;
                seed      = 16'h1234;
            end else begin
                start     = 1'b0;
                seed_load = 1'b0;
            end
            if (TVALID) begin
                case (mode)
                    0:       TREADY = 1'b1;
                    1:       TREADY = (since < 8) ? ready_pat[since][0] : 1'b1;
                    default: TREADY = 1'($urandom_range(0, 1));
                endcase
                since++;
                if (stalled && (TDATA !== held_data || TLAST !== held_last)) stall_viol++;
                held_data = TDATA;
                held_last = TLAST;
                stalled   = !TREADY;
                if (TREADY) begin
                    got_data.push_back(TDATA);
                    got_last.push_back(TLAST);
                end
            end else begin
                TREADY = 1'b0;
                valid_drops++;
            end
            @(posedge ACLK); #1;
            if (got_last.size() > 0 && got_last[got_last.size()-1]) begin
                start        = 1'b0;
                seed_load    = 1'b0;
                TREADY       = 1'b0;
                frame_cycles = c + 1;
                done_pulse1  = done;
                tvalid_after = TVALID;
                @(posedge ACLK); #1;
                done_pulse2  = done;
                return;
            end
        end
        timed_out    = 1'b1;
        frame_cycles = budget;
        start        = 1'b0;
        seed_load    = 1'b0;
        TREADY       = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0;
        frame_len = '0; TREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        vectors++;
        if ({TVALID, TLAST, done, busy} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: {TVALID,TLAST,done,busy}=%b, need 0000", {TVALID, TLAST, done, busy});
        end
        vectors++;
        if (TDATA !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_tdata: got %h, need 0", TDATA);
        end
        vectors++;
        if (frame_max !== '0 || frame_count !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_stats: max=%h count=%0d, need 0/0", frame_max, frame_count);
        end
        ARESET = 1'b0;
        mdl_lfsr  = 1;
        mdl_count = 0;
        @(posedge ACLK); #1;
    endtask

    task automatic test_basic_frame();
        logic [15:0] plan[4] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
        model_frame(4);
        applyStimulus(4, 1'b0, 16'h0000);
        vectors++;
        if (TVALID !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: TVALID=%b busy=%b, need 1/1", TVALID, busy);
        end
        collect(50, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 4 || frame_cycles != 4 || valid_drops != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_beats: beats=%0d cycles=%0d drops=%0d, need 4/4/0", got_data.size(), frame_cycles, valid_drops);
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            vectors++;
            if ({got_last[i], got_data[i]} !== {(i == 3), 16'h0000, plan[i]}) begin
                miscompares++;
                $display("[TB] FAIL basic_beat%0d: last=%b data=%h, need last=%b data=%h", i, got_last[i], got_data[i], (i == 3), plan[i]);
            end
        end
        vectors++;
        if ({done_pulse1, done_pulse2, tvalid_after} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL basic_done: {done,done+1,TVALID}=%b, need 100", {done_pulse1, done_pulse2, tvalid_after});
        end
        vectors++;
        if (frame_max !== 16'hB400 || frame_count !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL basic_stats: max=%h count=%0d, need b400/1", frame_max, frame_count);
        end
    endtask

    task automatic test_single_beat();
        model_frame(1);
        applyStimulus(1, 1'b0, 16'h0000);
        collect(20, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 1 || got_data[0] !== 32'h0000_1680 || got_last[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_beat: beats=%0d first=%h, need 1 beat 00001680 with TLAST", got_data.size(), (got_data.size() > 0) ? got_data[0] : '0);
        end
        vectors++;
        if (frame_max !== 16'h1680 || frame_count !== 8'd2 || done_pulse1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_stats: max=%h count=%0d done=%b, need 1680/2/1", frame_max, frame_count, done_pulse1);
        end
    endtask

    task automatic test_zero_seed();
        model_seed(16'h0000);
        model_frame(2);
        applyStimulus(2, 1'b1, 16'h0000);
        collect(20, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL zseed_beats: beats=%0d, need 2", got_data.size());
        end else begin
            vectors++;
            if (got_data[0] !== 32'h0000_0001 || got_data[1] !== 32'h0000_B400 || got_last[1] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL zseed_data: got %h,%h, need 00000001,0000b400", got_data[0], got_data[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] plan[4] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
        model_seed(16'h0001);
        model_frame(4);
        applyStimulus(4, 1'b1, 16'h0001);
        collect(50, 1, -1);
        vectors++;
        if (timed_out || got_data.size() != 4 || stall_viol != 0 || valid_drops != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_protocol: beats=%0d stall_changes=%0d drops=%0d, need 4/0/0", got_data.size(), stall_viol, valid_drops);
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            vectors++;
            if ({got_last[i], got_data[i]} !== {(i == 3), 16'h0000, plan[i]}) begin
                miscompares++;
                $display("[TB] FAIL bp_beat%0d: last=%b data=%h, need last=%b data=%h", i, got_last[i], got_data[i], (i == 3), plan[i]);
            end
        end
        vectors++;
        if (frame_max !== exp_max || frame_count !== CW'(mdl_count)) begin
            miscompares++;
            $display("[TB] FAIL bp_stats: max=%h count=%0d, need %h/%0d", frame_max, frame_count, exp_max, mdl_count);
        end
    endtask

    task automatic test_ignored_starts();
        bit seen_activity;
        // Zero-length request in IDLE.
        seen_activity = 1'b0;
        applyStimulus(0, 1'b0, 16'h0000);
        repeat (3) begin
            if (TVALID || busy || done) seen_activity = 1'b1;
            @(posedge ACLK); #1;
        end
        vectors++;
        if (seen_activity || frame_count !== CW'(mdl_count)) begin
            miscompares++;
            $display("[TB] FAIL zero_len: activity=%b count=%0d, need 0/%0d", seen_activity, frame_count, mdl_count);
        end
        // start and seed_load raised mid-frame must leave the frame untouched.
        model_frame(3);
        applyStimulus(3, 1'b0, 16'h0000);
        collect(30, 0, 1);
        vectors++;
        if (timed_out || got_data.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL busy_start_beats: beats=%0d, need 3", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            vectors++;
            if (got_data[i] !== {16'h0000, exp_words[i]}) begin
                miscompares++;
                $display("[TB] FAIL busy_start_beat%0d: got %h, need %h", i, got_data[i], exp_words[i]);
            end
        end
        seen_activity = 1'b0;
        repeat (4) begin
            if (TVALID) seen_activity = 1'b1;
            @(posedge ACLK); #1;
        end
        vectors++;
        if (seen_activity || frame_count !== CW'(mdl_count)) begin
            miscompares++;
            $display("[TB] FAIL busy_start_queued: extra_frame=%b count=%0d, need 0/%0d", seen_activity, frame_count, mdl_count);
        end
    endtask

    task automatic test_random_frames();
        int          len;
        bit          do_seed;
        logic [15:0] sd;
        for (int f = 0; f < 10; f++) begin
            len     = $urandom_range(1, 9);
            do_seed = 1'($urandom_range(0, 1));
            sd      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
            if (do_seed) model_seed(sd);
            model_frame(len);
            applyStimulus(len, do_seed, sd);
            collect(400, 2, -1);
            vectors++;
            if (timed_out || got_data.size() != len || stall_viol != 0 || valid_drops != 0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_protocol: beats=%0d stall_changes=%0d drops=%0d, need %0d/0/0", f, got_data.size(), stall_viol, valid_drops, len);
            end
            for (int i = 0; i < got_data.size() && i < len; i++) begin
                vectors++;
                if ({got_last[i], got_data[i]} !== {(i == len - 1), 16'h0000, exp_words[i]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_beat%0d: last=%b data=%h, need last=%b data=%h", f, i, got_last[i], got_data[i], (i == len - 1), exp_words[i]);
                end
            end
            vectors++;
            if (frame_max !== exp_max || frame_count !== CW'(mdl_count) || done_pulse1 !== 1'b1 || done_pulse2 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_stats: max=%h count=%0d done=%b%b, need %h/%0d/10", f, frame_max, frame_count, done_pulse1, done_pulse2, exp_max, mdl_count);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge ACLK); #1;
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit saw_done;
        applyStimulus(4, 1'b0, 16'h0000);
        TREADY = 1'b1;
        repeat (2) begin
            @(posedge ACLK); #1;
        end
        TREADY = 1'b0;
        #2 ARESET = 1'b1;
        #1;
        vectors++;
        if ({TVALID, TLAST, busy, done} !== 4'b0000 || TDATA !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: {TVALID,TLAST,busy,done}=%b TDATA=%h, need 0000/0", {TVALID, TLAST, busy, done}, TDATA);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge ACLK); #1;
            if (done) saw_done = 1'b1;
        end
        ARESET = 1'b0;
        mdl_lfsr  = 1;
        mdl_count = 0;
        repeat (2) begin
            @(posedge ACLK); #1;
            if (done || TVALID) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done || frame_count !== '0 || frame_max !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_abandon: done_or_valid=%b count=%0d max=%h, need 0/0/0", saw_done, frame_count, frame_max);
        end
        model_frame(2);
        applyStimulus(2, 1'b0, 16'h0000);
        collect(20, 0, -1);
        vectors++;
        if (timed_out || got_data.size() != 2 || got_data[0] !== 32'h0000_0001 || got_data[1] !== 32'h0000_B400) begin
            miscompares++;
            $display("[TB] FAIL reset_restart: beats=%0d first=%h, need 2 beats 00000001,0000b400", got_data.size(), (got_data.size() > 0) ? got_data[0] : '0);
        end
        vectors++;
        if (frame_count !== 8'd1 || frame_max !== exp_max) begin
            miscompares++;
            $display("[TB] FAIL reset_restart_stats: count=%0d max=%h, need 1/%h", frame_count, frame_max, exp_max);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_zero_seed();
        test_backpressure();
        test_ignored_starts();
        test_random_frames();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
